// File: rtl/fetch_queue_pkg.sv
// Shared pipeline package for the fetch stage.
//   XLEN_DEFAULT      default address/instruction width
//   NOP_WORD_DEFAULT  instruction presented downstream when the queue is empty
//   fetch_entry_t     one queued fetch: {instruction, pc}
package fetch_queue_pkg;

   localparam int          XLEN_DEFAULT     = 32;
   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] instruction;
      logic [XLEN_DEFAULT-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_storage.sv
// Entry storage for the fetch queue.
//   clk    negedge-active pipeline clock
//   we     write enable; waddr/wdata written on the active edge
//   raddr  combinational read address; rdata follows it directly
// The array has no reset; the owner masks outputs with its own valid flag.
module fetch_queue_storage #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(negedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// First-word-fall-through instruction fetch queue.
//   clk, rst_n        pipeline clock (state moves on negedge), async active-low reset
//   stall             decode not ready; head is held
//   jump_enable/addr  redirect: flush queue and reload fetch pc
//   imem_address      fetch address (the fetch pc register)
//   imem_instruction  combinational memory data for imem_address
//   instruction, pc, next_address, valid, occupancy  head entry view and fill level
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_WORD_DEFAULT)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       stall,
   input  logic                       jump_enable,
   input  logic [XLEN-1:0]            jump_address,
   output logic [XLEN-1:0]            imem_address,
   input  logic [XLEN-1:0]            imem_instruction,
   output logic [XLEN-1:0]            instruction,
   output logic [XLEN-1:0]            pc,
   output logic [XLEN-1:0]            next_address,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);

   logic [XLEN-1:0]   fetch_pc;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              full;
   logic              pop;
   logic              push;
   logic [2*XLEN-1:0] head;
   logic [XLEN-1:0]   head_instr;
   logic [XLEN-1:0]   head_pc;

   assign valid = (occupancy != '0);
   assign full  = (occupancy == OW'(DEPTH));

   // A redirect discards both the pending pop and the pending push.
   assign pop  = valid & ~stall & ~jump_enable;
   assign push = ~jump_enable & (~full | pop);

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc  <= RESET_PC;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else if (jump_enable) begin
         fetch_pc  <= {jump_address[XLEN-1:2], 2'b00};
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            wr_ptr   <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         occupancy <= occupancy + OW'(push) - OW'(pop);
      end
   end

   fetch_queue_storage #(
      .WIDTH (2*XLEN),
      .DEPTH (DEPTH)
   ) u_storage (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata ({imem_instruction, fetch_pc}),
      .raddr (rd_ptr),
      .rdata (head)
   );

   assign head_instr   = head[2*XLEN-1:XLEN];
   assign head_pc      = head[XLEN-1:0];

   assign imem_address = fetch_pc;
   assign instruction  = valid ? head_instr : NOP_WORD;
   assign pc           = valid ? head_pc : '0;
   assign next_address = valid ? head_pc + XLEN'(4) : '0;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int          DEPTH   = 4;
   localparam logic [31:0] RPC     = 32'h0;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic        clk = 1'b1;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        jump_enable = 1'b0;
   logic [31:0] jump_address = '0;
   logic [31:0] imem_address, imem_instruction;
   logic [31:0] instruction, pc, next_address;
   logic        valid;
   logic [2:0]  occupancy;
   logic [31:0] mem_key = '0;

   // Memory model: data is the address, optionally scrambled by a key
   assign imem_instruction = imem_address ^ mem_key;

   fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) u_dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .jump_enable(jump_enable),
      .jump_address(jump_address), .imem_address(imem_address),
      .imem_instruction(imem_instruction), .instruction(instruction), .pc(pc),
      .next_address(next_address), .valid(valid), .occupancy(occupancy));

   logic        rst_w_n = 1'b0;
   logic [31:0] w_imem_address, w_instruction, w_pc, w_next;
   logic        w_valid;
   logic [2:0]  w_occ;

   fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
      .clk(clk), .rst_n(rst_w_n), .stall(1'b0), .jump_enable(1'b0),
      .jump_address(32'h0), .imem_address(w_imem_address),
      .imem_instruction(w_imem_address), .instruction(w_instruction), .pc(w_pc),
      .next_address(w_next), .valid(w_valid), .occupancy(w_occ));

   int checks = 0;
   int errors = 0;

   fetch_entry_t mq[$];
   logic [31:0]  mpc = RPC;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One active edge: drive inputs, update the reference queue at the negedge,
   // return at the following posedge where outputs are stable.
   task automatic step(input logic st, input logic jp, input logic [31:0] ja);
      fetch_entry_t e;
      stall = st;
      jump_enable = jp;
      jump_address = ja;
      @(negedge clk);
      if (jp) begin
         mq.delete();
         mpc = {ja[31:2], 2'b00};
      end else begin
         if (mq.size() > 0 && !st) void'(mq.pop_front());
         if (mq.size() < DEPTH) begin
            e.instruction = mpc ^ mem_key;
            e.pc = mpc;
            mq.push_back(e);
            mpc = mpc + 32'd4;
         end
      end
      @(posedge clk);
   endtask

   task automatic check_model(input string tag);
      logic        ev;
      logic [31:0] ei, ep, en;
      ev = (mq.size() > 0);
      ei = ev ? mq[0].instruction : NOP;
      ep = ev ? mq[0].pc : 32'h0;
      en = ev ? mq[0].pc + 32'd4 : 32'h0;
      chk({tag, "_valid"}, 32'(valid), 32'(ev));
      chk({tag, "_occ"}, 32'(occupancy), mq.size());
      chk({tag, "_instr"}, instruction, ei);
      chk({tag, "_pc"}, pc, ep);
      chk({tag, "_next"}, next_address, en);
      chk({tag, "_imem"}, imem_address, mpc);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      rst_n = 1'b0;
      stall = 1'b0;
      jump_enable = 1'b0;
      mq.delete();
      mpc = RPC;
      #1;
      check_model(tag);
      @(posedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        st;
      logic        jp;
      logic [31:0] ja;
      int          occ;
      logic        v;
      logic [31:0] hpc;
      logic [31:0] imem;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [31:0] exp_pc[3];
      logic [31:0] exp_nx[3];

      // stall fill, jump from full, refill, jump while a pop is pending
      vecs[0]  = '{1'b1, 1'b0, 32'h0,   1, 1'b1, 32'h000, 32'h004};
      vecs[1]  = '{1'b1, 1'b0, 32'h0,   2, 1'b1, 32'h000, 32'h008};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,   3, 1'b1, 32'h000, 32'h00C};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,   4, 1'b1, 32'h000, 32'h010};
      vecs[4]  = '{1'b1, 1'b0, 32'h0,   4, 1'b1, 32'h000, 32'h010};
      vecs[5]  = '{1'b1, 1'b1, 32'h102, 0, 1'b0, 32'h000, 32'h100};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h100, 32'h104};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h104, 32'h108};
      vecs[8]  = '{1'b1, 1'b0, 32'h0,   2, 1'b1, 32'h104, 32'h10C};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,   2, 1'b1, 32'h108, 32'h110};
      vecs[10] = '{1'b0, 1'b1, 32'h203, 0, 1'b0, 32'h000, 32'h200};
      vecs[11] = '{1'b0, 1'b0, 32'h0,   1, 1'b1, 32'h200, 32'h204};

      do_reset("rst0");
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].st, vecs[i].jp, vecs[i].ja);
         chk($sformatf("vec%0d_occ", i), 32'(occupancy), vecs[i].occ);
         chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].v));
         chk($sformatf("vec%0d_pc", i), pc, vecs[i].hpc);
         chk($sformatf("vec%0d_instr", i), instruction, vecs[i].v ? vecs[i].hpc : NOP);
         chk($sformatf("vec%0d_next", i), next_address, vecs[i].v ? vecs[i].hpc + 32'd4 : 32'h0);
         chk($sformatf("vec%0d_imem", i), imem_address, vecs[i].imem);
      end

      // Free-running fetch, one entry in flight
      do_reset("rst1");
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, 32'h0);
         chk($sformatf("run%0d_pc", i), pc, 32'(4 * i));
         chk($sformatf("run%0d_occ", i), 32'(occupancy), 1);
      end

      // Drain after a stall fill: heads in order, no loss or duplication
      do_reset("rst2");
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
      chk("fill_imem", imem_address, 32'h10);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("drain%0d_pc", i), pc, 32'(4 * i));
         step(1'b0, 1'b0, 32'h0);
      end

      // Asynchronous reset between edges with three entries queued
      do_reset("rst3");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
      chk("pre_async_occ", 32'(occupancy), 3);
      #2;
      rst_n = 1'b0;
      mq.delete();
      mpc = RPC;
      #1;
      check_model("async");
      #1;
      rst_n = 1'b1;
      step(1'b0, 1'b0, 32'h0);
      check_model("restart");
      chk("restart_pc", pc, RPC);

      // Address wrap from a high reset pc
      exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
      exp_nx = '{32'hFFFF_FFFC, 32'h0, 32'h4};
      @(posedge clk);
      rst_w_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         @(posedge clk);
         chk($sformatf("wrap%0d_pc", i), w_pc, exp_pc[i]);
         chk($sformatf("wrap%0d_next", i), w_next, exp_nx[i]);
         chk($sformatf("wrap%0d_instr", i), w_instruction, exp_pc[i]);
      end

      // Randomized traffic against the queue model
      do_reset("rst4");
      mem_key = $urandom;
      for (int i = 0; i < 600; i++) begin
         logic st, jp;
         st = ((i / 40) % 2 == 0) ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 25);
         jp = ($urandom_range(0, 99) < 6);
         step(st, jp, $urandom);
         check_model($sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32: address and instruction width.
REQ-002 Parameter DEPTH, default 4: queue entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 Parameter NOP_WORD, default 32'h0000_0013: instruction presented when no valid entry.
REQ-005 clk  input  1  single clock; all state updates on negedge clk, matching the pipeline stage convention.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 stall  input  1  decode not ready; head is not consumed.
REQ-008 jump_enable  input  1  redirect request from execute.
REQ-009 jump_address  input  XLEN  redirect target.
REQ-010 imem_address  output  XLEN  fetch address to instruction memory (= pc register).
REQ-011 imem_instruction  input  XLEN  combinational memory read data for imem_address.
REQ-012 instruction  output  XLEN  head entry instruction, or NOP_WORD when empty.
REQ-013 pc  output  XLEN  head entry address, or 0 when empty.
REQ-014 next_address  output  XLEN  head pc + 4, or 0 when empty.
REQ-015 valid  output  1  queue non-empty.
REQ-016 occupancy  output  clog2(DEPTH+1)  current entry count.

Function
REQ-017 Queue is first-word-fall-through; instruction/pc/next_address/valid derive directly from the head entry.
REQ-018 Pop occurs on a clock edge when valid=1, stall=0 and jump_enable=0.
REQ-019 Push of {imem_instruction, pc} occurs when jump_enable=0 and (occupancy<DEPTH or pop in the same edge); the pc register then advances by 4.
REQ-020 When full with no pop, no push occurs and pc holds.
REQ-021 Simultaneous push and pop keeps occupancy unchanged; full-with-pop still pushes.
REQ-022 jump_enable=1 has priority: all entries flushed (occupancy=0), pending pop and push discarded, pc loads {jump_address[XLEN-1:2],2'b00}.
REQ-023 Latency: jump at edge N -> target fetched during cycle N..N+1 -> pushed at edge N+1 -> valid=1 with pc=target after edge N+1.
REQ-024 pc and next_address arithmetic is modulo 2^XLEN; 0xFFFF_FFFC + 4 wraps to 0.
REQ-025 Read/write pointers are clog2(DEPTH) bits and wrap naturally; empty/full decided by occupancy.
REQ-026 stall has no effect on fetching until the queue fills.

Reset
REQ-027 While rst_n=0: pc=RESET_PC, occupancy=0, pointers=0, valid=0, instruction=NOP_WORD, pc output=0, next_address=0.
REQ-028 Reset asserted mid-operation discards all entries immediately (asynchronously).
REQ-029 First push occurs on the first active edge after rst_n deasserts, storing RESET_PC.
REQ-030 Entry storage array needs no reset; outputs are masked by valid.

Structure
REQ-031 NOP_WORD default, XLEN default and the {instruction, pc} entry struct typedef reside in the shared pipeline package.
REQ-032 One sub-module, fetch_queue_storage: DEPTH-entry register array with write port and combinational read port.
REQ-033 Pointer, occupancy and pc control logic reside in fetch_queue.

Verification
REQ-034 Reset release, stall=0, imem returns address as data -> valid after 1 edge; pc sequence 0,4,8,... one per edge; occupancy stays 1.
REQ-035 stall=1 held, DEPTH=4 -> occupancy 1,2,3,4 then holds; imem_address frozen at 0x10; release stall -> heads 0x0,0x4,... in order, no loss or duplication.
REQ-036 Full queue, jump_enable=1 to 0x102 for one edge -> occupancy 0, imem_address=0x100; next edge valid=1, pc=0x100, next_address=0x104.
REQ-037 jump_enable=1 with stall=0 and valid=1 in same edge -> head not consumed downstream, flush wins, no entry from old path emerges afterwards.
REQ-038 RESET_PC=0xFFFF_FFF8, stall=0 -> pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; next_address for 0xFFFF_FFFC equals 0x0.
REQ-039 rst_n pulsed low between clock edges with occupancy=3 -> valid=0, instruction=NOP_WORD immediately; restart from RESET_PC.
